// File: rtl/clock_calendar_core.sv
// Timekeeping core: second prescaler, leap-aware calendar chain and a debounced
// three-key field-setting FSM feeding the display mux and alarm/compare logic.
module clock_calendar_core #(
  parameter int TICKS_PER_SEC   = 32768,
  parameter int DEBOUNCE_CYCLES = 327,
  parameter int TWELVE_HOUR     = 0,
  parameter int YEAR_BASE       = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_add,
  input  logic       key_sub,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [2:0] field_sel,
  output logic       setting,
  output logic       blink,
  output logic       sec_tick
);

  localparam int PS_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(TICKS_PER_SEC / 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     YEAR_BASE_BITS = YEAR_BASE;

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_HOUR   = 3'd1;
  localparam logic [2:0] ST_MINUTE = 3'd2;
  localparam logic [2:0] ST_YEAR   = 3'd3;
  localparam logic [2:0] ST_MONTH  = 3'd4;
  localparam logic [2:0] ST_DAY    = 3'd5;

  // Days in month; leap rule is simply year offset divisible by four.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] len;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  function automatic logic [6:0] step_wrap(input logic [6:0] v, input logic [6:0] lo,
                                           input logic [6:0] hi, input logic up);
    logic [6:0] r;
    if (up) begin
      r = (v >= hi) ? lo : v + 7'd1;
    end else begin
      r = (v <= lo) ? hi : v - 7'd1;
    end
    return r;
  endfunction

  // YEAR_BASE is descriptive only; folding it into an unused net keeps it referenced.
  logic year_base_unused_s;
  assign year_base_unused_s = ^YEAR_BASE_BITS;

  logic [2:0]      key_raw_s;
  logic [2:0]      sync1_r, sync2_r, stable_r, stable_d_r, press_r;
  logic [DB_W-1:0] db_cnt_r [3];
  logic            mode_ev_s, add_ev_s, sub_ev_s;

  assign key_raw_s = {key_sub, key_add, key_mode};
  assign mode_ev_s = press_r[0];
  assign add_ev_s  = press_r[1] & ~press_r[2] & ~press_r[0];
  assign sub_ev_s  = press_r[2] & ~press_r[1] & ~press_r[0];

  // Per-key synchroniser, debounce counter and registered press pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r    <= 3'b000;
      sync2_r    <= 3'b000;
      stable_r   <= 3'b000;
      stable_d_r <= 3'b000;
      press_r    <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= {DB_W{1'b0}};
    end else begin
      sync1_r    <= key_raw_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
          stable_r[i] <= sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  logic [2:0] state_r, state_next_s;
  logic       run_s, exit_s, edit_s;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: mode events walk the field ring
  always_comb begin
    state_next_s = state_r;
    if (mode_ev_s) begin
      case (state_r)
        ST_RUN:    state_next_s = ST_HOUR;
        ST_HOUR:   state_next_s = ST_MINUTE;
        ST_MINUTE: state_next_s = ST_YEAR;
        ST_YEAR:   state_next_s = ST_MONTH;
        ST_MONTH:  state_next_s = ST_DAY;
        default:   state_next_s = ST_RUN;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM outputs: chain enable, SET_DAY exit strobe, field edit strobe
  always_comb begin
    run_s  = 1'b0;
    exit_s = 1'b0;
    edit_s = 1'b0;
    case (state_r)
      ST_RUN:  run_s  = 1'b1;
      ST_DAY:  begin
        exit_s = mode_ev_s;
        edit_s = add_ev_s | sub_ev_s;
      end
      default: edit_s = add_ev_s | sub_ev_s;
    endcase
  end

  logic [PS_W-1:0] presc_r, presc_n_s;
  logic [5:0] sec_r, min_r, sec_n_s, min_n_s;
  logic [4:0] hour_r, hour_n_s, day_r, day_pre_s, day_n_s, cur_len_s, new_len_s;
  logic [3:0] month_r, month_n_s;
  logic [6:0] year_r, year_n_s;
  logic       tick_s, blink_r, tick_r;
  logic       sec_wrap_s, min_wrap_s, hour_wrap_s, day_wrap_s, month_wrap_s;

  assign tick_s       = run_s && (presc_r == PS_LAST);
  assign presc_n_s    = (exit_s || presc_r == PS_LAST) ? {PS_W{1'b0}} : presc_r + PS_W'(1);
  assign cur_len_s    = month_len(month_r, year_r);
  assign sec_wrap_s   = (sec_r == 6'd59);
  assign min_wrap_s   = sec_wrap_s && (min_r == 6'd59);
  assign hour_wrap_s  = min_wrap_s && (hour_r == 5'd23);
  assign day_wrap_s   = hour_wrap_s && (day_r == cur_len_s);
  assign month_wrap_s = day_wrap_s && (month_r == 4'd12);

  // Field next values: carry chain in RUN, single-field edits in set states
  always_comb begin
    sec_n_s   = sec_r;
    min_n_s   = min_r;
    hour_n_s  = hour_r;
    day_pre_s = day_r;
    month_n_s = month_r;
    year_n_s  = year_r;
    if (tick_s) begin
      sec_n_s   = 6'(step_wrap(7'(sec_r), 7'd0, 7'd59, 1'b1));
      min_n_s   = sec_wrap_s ? 6'(step_wrap(7'(min_r), 7'd0, 7'd59, 1'b1)) : min_r;
      hour_n_s  = min_wrap_s ? 5'(step_wrap(7'(hour_r), 7'd0, 7'd23, 1'b1)) : hour_r;
      day_pre_s = hour_wrap_s ? ((day_r == cur_len_s) ? 5'd1 : day_r + 5'd1) : day_r;
      month_n_s = day_wrap_s ? 4'(step_wrap(7'(month_r), 7'd1, 7'd12, 1'b1)) : month_r;
      year_n_s  = month_wrap_s ? step_wrap(year_r, 7'd0, 7'd99, 1'b1) : year_r;
    end else if (exit_s) begin
      sec_n_s = 6'd0;
    end else if (edit_s) begin
      case (state_r)
        ST_HOUR:   hour_n_s  = 5'(step_wrap(7'(hour_r), 7'd0, 7'd23, add_ev_s));
        ST_MINUTE: min_n_s   = 6'(step_wrap(7'(min_r), 7'd0, 7'd59, add_ev_s));
        ST_YEAR:   year_n_s  = step_wrap(year_r, 7'd0, 7'd99, add_ev_s);
        ST_MONTH:  month_n_s = 4'(step_wrap(7'(month_r), 7'd1, 7'd12, add_ev_s));
        ST_DAY:    day_pre_s = 5'(step_wrap(7'(day_r), 7'd1, 7'(cur_len_s), add_ev_s));
        default:   sec_n_s   = sec_r;
      endcase
    end else begin
      sec_n_s = sec_r;
    end
  end

  // A month or year edit can shorten the month under the current day.
  assign new_len_s = month_len(month_n_s, year_n_s);
  assign day_n_s   = (day_pre_s > new_len_s) ? new_len_s : day_pre_s;

  // Calendar, prescaler and status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r <= {PS_W{1'b0}};
      sec_r   <= 6'd0;
      min_r   <= 6'd0;
      hour_r  <= 5'd0;
      day_r   <= 5'd1;
      month_r <= 4'd1;
      year_r  <= 7'd0;
      tick_r  <= 1'b0;
      blink_r <= 1'b0;
    end else begin
      presc_r <= presc_n_s;
      sec_r   <= sec_n_s;
      min_r   <= min_n_s;
      hour_r  <= hour_n_s;
      day_r   <= day_n_s;
      month_r <= month_n_s;
      year_r  <= year_n_s;
      tick_r  <= tick_s;
      blink_r <= (presc_n_s < PS_HALF) && (state_next_s != ST_RUN);
    end
  end

  // Display hour, combinational from the hour register
  always_comb begin
    if (TWELVE_HOUR != 0) begin
      if (hour_r == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour_r > 5'd12) begin
        hour_disp = hour_r - 5'd12;
      end else begin
        hour_disp = hour_r;
      end
      pm = (hour_r >= 5'd12);
    end else begin
      hour_disp = hour_r;
      pm        = 1'b0;
    end
  end

  assign second    = sec_r;
  assign minute    = min_r;
  assign hour      = hour_r;
  assign day       = day_r;
  assign month     = month_r;
  assign year      = year_r;
  assign field_sel = state_r;
  assign setting   = (state_r != ST_RUN);
  assign blink     = blink_r;
  assign sec_tick  = tick_r;

endmodule

// File: tb/tb_clock_calendar_core.sv
// Directed bench for clock_calendar_core with 8 ticks/s, 4-cycle debounce, 12-hour display.
module tb_clock_calendar_core;

  localparam int OP_MODE = 0, OP_ADD = 1, OP_SUB = 2, OP_BOTH = 3, OP_MODE_ADD = 4;

  logic       clock, reset, key_mode, key_add, key_sub;
  logic [5:0] second, minute;
  logic [4:0] hour, hour_disp, day;
  logic       pm, setting, blink, sec_tick;
  logic [3:0] month;
  logic [6:0] year;
  logic [2:0] field_sel;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int op;
    int fs;
    int hour;
    int minute;
    int year;
    int month;
    int day;
  } vec_t;

  vec_t vecs [56];

  clock_calendar_core #(
    .TICKS_PER_SEC(8), .DEBOUNCE_CYCLES(4), .TWELVE_HOUR(1), .YEAR_BASE(2000)
  ) dut (
    .clock(clock), .reset(reset), .key_mode(key_mode), .key_add(key_add), .key_sub(key_sub),
    .second(second), .minute(minute), .hour(hour), .hour_disp(hour_disp), .pm(pm),
    .day(day), .month(month), .year(year), .field_sel(field_sel), .setting(setting),
    .blink(blink), .sec_tick(sec_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold the selected keys for 10 cycles, then release and let them settle.
  task automatic press(input int op);
    key_mode = (op == OP_MODE) || (op == OP_MODE_ADD);
    key_add  = (op == OP_ADD) || (op == OP_BOTH) || (op == OP_MODE_ADD);
    key_sub  = (op == OP_SUB) || (op == OP_BOTH);
    repeat (10) @(negedge clock);
    key_mode = 1'b0;
    key_add  = 1'b0;
    key_sub  = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(vecs[i].op);
      check($sformatf("v%0d field_sel", i), int'(field_sel), vecs[i].fs);
      check($sformatf("v%0d hour", i), int'(hour), vecs[i].hour);
      check($sformatf("v%0d minute", i), int'(minute), vecs[i].minute);
      check($sformatf("v%0d year", i), int'(year), vecs[i].year);
      check($sformatf("v%0d month", i), int'(month), vecs[i].month);
      check($sformatf("v%0d day", i), int'(day), vecs[i].day);
    end
  endtask

  // Leave SET_DAY at 23:59, then follow exact tick timing up to and across midnight.
  task automatic roll_check(input int pre_d, input int pre_m, input int pre_y,
                            input int post_d, input int post_m, input int post_y);
    press(OP_MODE);
    check("exit field_sel", int'(field_sel), 0);
    check("exit second", int'(second), 1);
    @(negedge clock);
    check("exit tick idle", int'(sec_tick), 0);
    @(negedge clock);
    check("restart tick", int'(sec_tick), 1);
    check("restart second", int'(second), 2);
    repeat (456) @(negedge clock);
    check("pre second", int'(second), 59);
    check("pre minute", int'(minute), 59);
    check("pre hour", int'(hour), 23);
    check("pre hour_disp", int'(hour_disp), 11);
    check("pre pm", int'(pm), 1);
    check("pre day", int'(day), pre_d);
    check("pre month", int'(month), pre_m);
    check("pre year", int'(year), pre_y);
    repeat (8) @(negedge clock);
    check("roll sec_tick", int'(sec_tick), 1);
    check("roll second", int'(second), 0);
    check("roll minute", int'(minute), 0);
    check("roll hour", int'(hour), 0);
    check("roll hour_disp", int'(hour_disp), 12);
    check("roll pm", int'(pm), 0);
    check("roll day", int'(day), post_d);
    check("roll month", int'(month), post_m);
    check("roll year", int'(year), post_y);
  endtask

  initial begin
    int blink_hi;
    // op, field_sel, hour, minute, year, month, day after the press
    vecs[0]  = '{OP_BOTH, 1, 0, 0, 0, 1, 1};
    vecs[1]  = '{OP_SUB, 1, 23, 0, 0, 1, 1};
    vecs[2]  = '{OP_ADD, 1, 0, 0, 0, 1, 1};
    vecs[3]  = '{OP_SUB, 1, 23, 0, 0, 1, 1};
    vecs[4]  = '{OP_MODE, 2, 23, 0, 0, 1, 1};
    vecs[5]  = '{OP_SUB, 2, 23, 59, 0, 1, 1};
    vecs[6]  = '{OP_MODE, 3, 23, 59, 0, 1, 1};
    vecs[7]  = '{OP_SUB, 3, 23, 59, 99, 1, 1};
    vecs[8]  = '{OP_MODE, 4, 23, 59, 99, 1, 1};
    vecs[9]  = '{OP_SUB, 4, 23, 59, 99, 12, 1};
    vecs[10] = '{OP_MODE, 5, 23, 59, 99, 12, 1};
    vecs[11] = '{OP_SUB, 5, 23, 59, 99, 12, 31};
    vecs[12] = '{OP_ADD, 5, 23, 59, 99, 12, 1};
    vecs[13] = '{OP_SUB, 5, 23, 59, 99, 12, 31};
    vecs[14] = '{OP_ADD, 0, 0, 0, 0, 1, 1};
    vecs[15] = '{OP_MODE, 1, 0, 0, 0, 1, 1};
    vecs[16] = '{OP_MODE, 2, 0, 0, 0, 1, 1};
    vecs[17] = '{OP_MODE, 3, 0, 0, 0, 1, 1};
    vecs[18] = '{OP_MODE, 4, 0, 0, 0, 1, 1};
    vecs[19] = '{OP_MODE, 5, 0, 0, 0, 1, 1};
    vecs[20] = '{OP_SUB, 5, 0, 0, 0, 1, 31};
    vecs[21] = '{OP_MODE, 0, 0, 0, 0, 1, 31};
    vecs[22] = '{OP_MODE, 1, 0, 0, 0, 1, 31};
    vecs[23] = '{OP_MODE, 2, 0, 0, 0, 1, 31};
    vecs[24] = '{OP_MODE, 3, 0, 0, 0, 1, 31};
    vecs[25] = '{OP_MODE, 4, 0, 0, 0, 1, 31};
    vecs[26] = '{OP_ADD, 4, 0, 0, 0, 2, 29};
    vecs[27] = '{OP_MODE, 5, 0, 0, 0, 2, 29};
    vecs[28] = '{OP_MODE, 0, 0, 0, 0, 2, 29};
    vecs[29] = '{OP_MODE, 1, 0, 0, 0, 2, 29};
    vecs[30] = '{OP_MODE, 2, 0, 0, 0, 2, 29};
    vecs[31] = '{OP_MODE, 3, 0, 0, 0, 2, 29};
    vecs[32] = '{OP_SUB, 3, 0, 0, 99, 2, 28};
    vecs[33] = '{OP_MODE_ADD, 4, 0, 0, 99, 2, 28};
    vecs[34] = '{OP_MODE, 5, 0, 0, 99, 2, 28};
    vecs[35] = '{OP_MODE, 0, 0, 0, 99, 2, 28};
    vecs[36] = '{OP_MODE, 1, 0, 0, 99, 2, 28};
    vecs[37] = '{OP_SUB, 1, 23, 0, 99, 2, 28};
    vecs[38] = '{OP_MODE, 2, 23, 0, 99, 2, 28};
    vecs[39] = '{OP_SUB, 2, 23, 59, 99, 2, 28};
    vecs[40] = '{OP_MODE, 3, 23, 59, 99, 2, 28};
    vecs[41] = '{OP_ADD, 3, 23, 59, 0, 2, 28};
    vecs[42] = '{OP_ADD, 3, 23, 59, 1, 2, 28};
    vecs[43] = '{OP_ADD, 3, 23, 59, 2, 2, 28};
    vecs[44] = '{OP_ADD, 3, 23, 59, 3, 2, 28};
    vecs[45] = '{OP_ADD, 3, 23, 59, 4, 2, 28};
    vecs[46] = '{OP_MODE, 4, 23, 59, 4, 2, 28};
    vecs[47] = '{OP_MODE, 5, 23, 59, 4, 2, 28};
    vecs[48] = '{OP_MODE, 1, 0, 0, 4, 2, 29};
    vecs[49] = '{OP_SUB, 1, 23, 0, 4, 2, 29};
    vecs[50] = '{OP_MODE, 2, 23, 0, 4, 2, 29};
    vecs[51] = '{OP_SUB, 2, 23, 59, 4, 2, 29};
    vecs[52] = '{OP_MODE, 3, 23, 59, 4, 2, 29};
    vecs[53] = '{OP_ADD, 3, 23, 59, 5, 2, 28};
    vecs[54] = '{OP_MODE, 4, 23, 59, 5, 2, 28};
    vecs[55] = '{OP_MODE, 5, 23, 59, 5, 2, 28};

    reset    = 1'b1;
    key_mode = 1'b0;
    key_add  = 1'b0;
    key_sub  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset second", int'(second), 0);
    check("reset minute", int'(minute), 0);
    check("reset hour", int'(hour), 0);
    check("reset day", int'(day), 1);
    check("reset month", int'(month), 1);
    check("reset year", int'(year), 0);
    check("reset field_sel", int'(field_sel), 0);
    check("reset setting", int'(setting), 0);
    check("reset blink", int'(blink), 0);
    check("reset sec_tick", int'(sec_tick), 0);
    check("reset hour_disp", int'(hour_disp), 12);
    check("reset pm", int'(pm), 0);
    reset = 1'b0;

    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      check($sformatf("tick cycle %0d", c), int'(sec_tick), (c % 8 == 0) ? 1 : 0);
    end
    check("tick rate second", int'(second), 10);
    check("run blink", int'(blink), 0);

    // Mode key first sampled at edge N=83: event after N+6, field change at N+7.
    repeat (2) @(negedge clock);
    key_mode = 1'b1;
    repeat (7) @(negedge clock);
    check("debounce not early", int'(field_sel), 0);
    check("second before set", int'(second), 11);
    @(negedge clock);
    check("debounce lands", int'(field_sel), 1);
    check("setting high", int'(setting), 1);
    repeat (2) @(negedge clock);
    key_mode = 1'b0;
    repeat (16) @(negedge clock);
    check("single mode event", int'(field_sel), 1);
    check("second frozen", int'(second), 11);
    blink_hi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (blink) blink_hi++;
      check("set no sec_tick", int'(sec_tick), 0);
    end
    check("blink duty", blink_hi, 4);

    key_add = 1'b1;
    repeat (3) @(negedge clock);
    key_add = 1'b0;
    repeat (15) @(negedge clock);
    check("glitch ignored", int'(hour), 0);

    run_rows(0, 13);
    roll_check(31, 12, 99, 1, 1, 0);
    run_rows(14, 47);
    roll_check(28, 2, 4, 29, 2, 4);
    run_rows(48, 55);
    roll_check(28, 2, 5, 1, 3, 5);

    press(OP_MODE);
    repeat (12) press(OP_ADD);
    check("h12 hour", int'(hour), 12);
    check("h12 hour_disp", int'(hour_disp), 12);
    check("h12 pm", int'(pm), 1);
    press(OP_ADD);
    check("h13 hour", int'(hour), 13);
    check("h13 hour_disp", int'(hour_disp), 1);
    check("h13 pm", int'(pm), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_calendar_core.md
# clock_calendar_core

Parametrised timekeeping core for the clock design: a second prescaler, a seconds/minutes/hours/day/month/year chain with leap-year-correct February, and a debounced three-key setting state machine. Field setting supports both increment and decrement, with date clamping and optional 12-hour display output. It replaces the fixed 24-hour, no-year timekeeping path. Its outputs feed the segment display multiplexer and the alarm and compare logic.

## Interface
- TICKS_PER_SEC, 32768: clock cycles per second; must be ≥ 4 and even.
- DEBOUNCE_CYCLES, 327: cycles a synchronised key must hold a new level before it is accepted.
- TWELVE_HOUR, 0: 1 = `hour_disp`/`pm` use 12-hour format; 0 = 24-hour passthrough.
- YEAR_BASE, 2000: documentation only; `year` is the offset 0–99, and leap year is defined as `year % 4 == 0`.

Ports:
- `clock` in 1: single clock. Every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-high.
- `key_mode` in 1: raw key, active high, asynchronous to `clock`.
- `key_add` in 1: raw key, active high.
- `key_sub` in 1: raw key, active high.
- `second` out 6: 0–59.
- `minute` out 6: 0–59.
- `hour` out 5: 0–23.
- `hour_disp` out 5: display hour.
- `pm` out 1: PM flag.
- `day` out 5: 1–31.
- `month` out 4: 1–12.
- `year` out 7: 0–99.
- `field_sel` out 3: 0 RUN, 1 SET_HOUR, 2 SET_MINUTE, 3 SET_YEAR, 4 SET_MONTH, 5 SET_DAY.
- `setting` out 1: high when `field_sel` ≠ 0.
- `blink` out 1: high in the first half of each prescaler period while `setting`, otherwise 0.
- `sec_tick` out 1: one-cycle pulse on each second increment.

## Operation
**Reset.** Reset drives these values on the next edge:
- second = minute = hour = 0, day = 1, month = 1, year = 0.
- `field_sel` = RUN, prescaler = 0.
- `sec_tick` = `blink` = 0, and all debounce state is cleared.
- With TWELVE_HOUR = 1: `hour_disp` = 12, `pm` = 0.

**Key conditioning.** Each key passes through the same stages:
- A 2-flop synchroniser, then a stable-level register and a debounce counter.
- The counter increments while the synchronised level ≠ the stable level, and clears otherwise.
- When the counter reaches DEBOUNCE_CYCLES − 1, the stable level takes the new value.
- A press event is a one-cycle pulse on a stable 0→1 transition. Releases generate no event.

**Prescaler.**
- Counts 0 … TICKS_PER_SEC − 1 and wraps. It runs in every state.

**RUN state.**
- When the prescaler = TICKS_PER_SEC − 1, `second` increments and `sec_tick` pulses.
- Carries ripple in the same edge: 59 → 0 on second and minute; 23 → 0 on hour.
- `day` wraps to 1 past its month length:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February is 29 if `year % 4 == 0`, else 28.
- `month` wraps 12 → 1. `year` wraps 99 → 0.

**Mode key.**
- A mode event advances `field_sel` RUN → SET_HOUR → SET_MINUTE → SET_YEAR → SET_MONTH → SET_DAY → RUN.
- The transition SET_DAY → RUN clears `second` and the prescaler on that edge.

**Set states.**
- No chain increments occur and `sec_tick` = 0.
- An add event increments the selected field; a sub event decrements it. Both wrap within the field range and never carry into other fields.
- Day range is 1 … current month length.
- After any month or year change, if `day` > the new month length, `day` is clamped to that length on the same edge.

**Simultaneous events.**
- Add and sub in the same cycle: both are ignored.
- Mode with add or sub in the same cycle: mode is applied, and add/sub are ignored.
- Add or sub in RUN: ignored.

**Display outputs.**
- With TWELVE_HOUR = 1:
  - `hour_disp` = 12 if hour = 0, hour − 12 if hour > 12, else hour.
  - `pm` = (hour ≥ 12).
- With TWELVE_HOUR = 0: `hour_disp` = hour and `pm` = 0.
- Both are combinational from the `hour` register.

## Timing
- All field outputs, `field_sel`, `sec_tick` and `blink` are registered.
- `hour_disp` and `pm` follow `hour` with zero added latency.
- Key latency: if the raw key is first sampled high at edge N and stays high, the press event is high during the cycle after edge N + 2 + DEBOUNCE_CYCLES. The field update lands on the following edge.
- A pulse shorter than DEBOUNCE_CYCLES cycles produces no event.
- `sec_tick` is high for exactly one cycle per TICKS_PER_SEC cycles in RUN, coincident with the updated `second` value.
- A full rollover completes in one edge: 23:59:59 Dec 31, year 99 → 00:00:00 Jan 1, year 0.
- Reset asserted mid-operation, including mid-debounce or in a set state, takes priority over every other event on that edge.
- `blink` = (prescaler < TICKS_PER_SEC/2) && `setting`.

## Test plan
- **Tick rate:** TICKS_PER_SEC = 8, run 80 cycles from reset → `second` = 10, with `sec_tick` high every 8th cycle.
- **Full rollover:** preload via keys to 23:59:59 Dec 31, year 99, then run one tick → 00:00:00, day 1, month 1, year 0, all on the same edge.
- **Leap year:** year = 4, Feb 28 23:59:59 plus one tick → Feb 29. With year = 5, the same stimulus → Mar 1.
- **Clamp:** day 31, month 1, enter SET_MONTH and add → month 2 and day 29 (year 0). Then SET_YEAR sub to 99 → day 28.
- **Debounce:** DEBOUNCE_CYCLES = 4. A glitch of 3 cycles → no event. A press held 10 cycles → exactly one event, at cycle N + 6. Add and sub pressed together → no change.
- **12-hour display:** TWELVE_HOUR = 1. hour 0 → `hour_disp` 12, `pm` 0. hour 12 → 12, `pm` 1. hour 13 → 1, `pm` 1. Exiting SET_DAY → `second` = 0 and the prescaler restarts.
